// File: rtl/motion_sequencer_if.sv
// Request/H-bridge bundle between the behaviour modules and the motion sequencer.
interface motion_sequencer_if;
    logic       req_brake;
    logic       req_reverse;
    logic       req_turn;
    logic       turn_dir;
    logic       req_forward;
    logic [3:0] h_bridge_ins;
    logic [1:0] enables;
    logic [3:0] grant;
    logic       busy;

    // Requester side: raises motion requests, observes the bridge drive.
    modport master (
        output req_brake, req_reverse, req_turn, turn_dir, req_forward,
        input  h_bridge_ins, enables, grant, busy
    );

    // Sequencer side: owns the bridge drive.
    modport slave (
        input  req_brake, req_reverse, req_turn, turn_dir, req_forward,
        output h_bridge_ins, enables, grant, busy
    );
endinterface

// File: rtl/motion_sequencer.sv
// Motion sequencer: single registered owner of the H-bridge pattern/enables.
// Priority brake > reverse > turn > forward, with minimum hold, coast dead-time
// between differing patterns and a timed hard brake.
// Optional macro SOFT_START_EN: PWM-ramps the enables during DRIVE.
module motion_sequencer #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEADTIME_CYC = 4,
    parameter int unsigned MIN_HOLD_CYC = 8,
    parameter int unsigned BRAKE_CYC    = 16,
    parameter int unsigned RAMP_CYC     = 8
) (
    input logic               clock,
    input logic               reset_n,
    motion_sequencer_if.slave bus
);

    localparam logic [3:0] INERTIAL_STOP = 4'b0000;
    localparam logic [3:0] HARD_STOP     = 4'b1111;
    localparam logic [3:0] REVERSE       = 4'b0110;
    localparam logic [3:0] FORWARD       = 4'b1001;
    localparam logic [3:0] TURN_RIGHT    = 4'b0101;
    localparam logic [3:0] TURN_LEFT     = 4'b1010;

    localparam int unsigned HOLD_LAST  = (MIN_HOLD_CYC > 1) ? MIN_HOLD_CYC - 1 : 0;
    localparam int unsigned DT_LAST    = (DEADTIME_CYC > 1) ? DEADTIME_CYC - 1 : 0;
    localparam int unsigned BRAKE_LAST = (BRAKE_CYC > 1) ? BRAKE_CYC - 1 : 0;

    // Reject configurations the dead-time and ramp counters cannot express.
    if (DEADTIME_CYC == 0 || RAMP_CYC == 0) begin : gBadParam
        $error("motion_sequencer: DEADTIME_CYC and RAMP_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        DEADTIME = 2'd2,
        BRAKE    = 2'd3
    } stateT;

    stateT            state, stateNext;
    logic [3:0]       pattern, patNext;
    logic [3:0]       owner, ownNext;
    logic [CNT_W-1:0] holdCnt, holdNext;
    logic [CNT_W-1:0] dtCnt, dtNext;
    logic [CNT_W-1:0] brCnt, brNext;
    logic [3:0]       winOwn;
    logic [3:0]       winPat;
    logic [3:0]       insNext;
    logic [1:0]       enNext;
    logic [3:0]       grantNext;
    logic             busyNext;

`ifdef SOFT_START_EN
    localparam int unsigned RAMP_LAST = RAMP_CYC - 1;
    logic [1:0]       phase, phaseNext;
    logic [2:0]       duty, dutyNext;
    logic [CNT_W-1:0] rampCnt, rampNext;
`endif

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            pattern          <= INERTIAL_STOP;
            owner            <= 4'b0000;
            holdCnt          <= '0;
            dtCnt            <= '0;
            brCnt            <= '0;
            bus.h_bridge_ins <= INERTIAL_STOP;
            bus.enables      <= 2'b00;
            bus.grant        <= 4'b0000;
            bus.busy         <= 1'b0;
        end else begin
            state            <= stateNext;
            pattern          <= patNext;
            owner            <= ownNext;
            holdCnt          <= holdNext;
            dtCnt            <= dtNext;
            brCnt            <= brNext;
            bus.h_bridge_ins <= insNext;
            bus.enables      <= enNext;
            bus.grant        <= grantNext;
            bus.busy         <= busyNext;
        end
    end

    // Priority winner, next state, latched pattern and counter updates.
    always_comb begin
        winOwn    = 4'b0000;
        winPat    = INERTIAL_STOP;
        stateNext = state;
        patNext   = pattern;
        ownNext   = owner;
        holdNext  = '0;
        dtNext    = '0;
        brNext    = '0;

        if (bus.req_brake) begin
            winOwn = 4'b1000;
            winPat = HARD_STOP;
        end else if (bus.req_reverse) begin
            winOwn = 4'b0100;
            winPat = REVERSE;
        end else if (bus.req_turn) begin
            winOwn = 4'b0010;
            winPat = bus.turn_dir ? TURN_RIGHT : TURN_LEFT;
        end else if (bus.req_forward) begin
            winOwn = 4'b0001;
            winPat = FORWARD;
        end

        case (state)
            IDLE: begin
                if (bus.req_brake) begin
                    stateNext = BRAKE;
                end else if (winOwn != 4'b0000) begin
                    stateNext = DRIVE;
                    patNext   = winPat;
                    ownNext   = winOwn;
                end
            end
            DRIVE: begin
                holdNext = satInc(holdCnt);
                if (bus.req_brake) begin
                    stateNext = BRAKE;
                end else if (holdCnt < CNT_W'(HOLD_LAST)) begin
                    stateNext = DRIVE;
                end else if (winOwn == 4'b0000 || winPat != pattern) begin
                    stateNext = DEADTIME;
                end
            end
            DEADTIME: begin
                dtNext = satInc(dtCnt);
                if (bus.req_brake) begin
                    stateNext = BRAKE;
                end else if (dtCnt >= CNT_W'(DT_LAST)) begin
                    if (winOwn == 4'b0000) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = DRIVE;
                        patNext   = winPat;
                        ownNext   = winOwn;
                    end
                end
            end
            BRAKE: begin
                brNext = satInc(brCnt);
                if (brCnt >= CNT_W'(BRAKE_LAST) && !bus.req_brake) begin
                    stateNext = DEADTIME;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (stateNext != state) begin
            holdNext = '0;
            dtNext   = '0;
            brNext   = '0;
        end
    end

    // Bridge drive decoded from the state being entered.
    always_comb begin
        insNext   = INERTIAL_STOP;
        enNext    = 2'b00;
        grantNext = 4'b0000;
        busyNext  = (stateNext != IDLE);
`ifdef SOFT_START_EN
        phaseNext = phase + 2'd1;
        dutyNext  = duty;
        rampNext  = '0;
        if (stateNext == DRIVE && state != DRIVE) begin
            dutyNext = 3'd1;
        end else if (stateNext == DRIVE) begin
            if (rampCnt >= CNT_W'(RAMP_LAST)) begin
                dutyNext = (duty >= 3'd4) ? 3'd4 : duty + 3'd1;
            end else begin
                rampNext = satInc(rampCnt);
            end
        end
`endif
        case (stateNext)
            DRIVE: begin
                insNext   = patNext;
                grantNext = ownNext;
`ifdef SOFT_START_EN
                enNext    = ({1'b0, phaseNext} < dutyNext) ? 2'b11 : 2'b00;
`else
                enNext    = 2'b11;
`endif
            end
            BRAKE: begin
                insNext   = HARD_STOP;
                enNext    = 2'b11;
                grantNext = 4'b1000;
            end
            default: begin
                insNext   = INERTIAL_STOP;
            end
        endcase
    end

`ifdef SOFT_START_EN
    // Free-running PWM phase and soft-start duty ramp.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase   <= 2'd0;
            duty    <= 3'd0;
            rampCnt <= '0;
        end else begin
            phase   <= phaseNext;
            duty    <= dutyNext;
            rampCnt <= rampNext;
        end
    end
`endif

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: reset, hold, dead-time, brake, release,
// direction flip, priority and mid-operation reset.
module tb_motion_sequencer;

    // Packed observation: {h_bridge_ins, enables, grant, busy}
    localparam logic [10:0] O_IDLE = 11'b0000_00_0000_0;
    localparam logic [10:0] O_DT   = 11'b0000_00_0000_1;
    localparam logic [10:0] O_FWD  = 11'b1001_11_0001_1;
    localparam logic [10:0] O_REV  = 11'b0110_11_0100_1;
    localparam logic [10:0] O_TR   = 11'b0101_11_0010_1;
    localparam logic [10:0] O_TL   = 11'b1010_11_0010_1;
    localparam logic [10:0] O_BRK  = 11'b1111_11_1000_1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   vecCount = 0;
    int   errCount = 0;

    motion_sequencer_if bus();

    motion_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] obs();
        return {bus.h_bridge_ins, bus.enables, bus.grant, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearReqs();
        bus.req_brake   = 1'b0;
        bus.req_reverse = 1'b0;
        bus.req_turn    = 1'b0;
        bus.turn_dir    = 1'b0;
        bus.req_forward = 1'b0;
    endtask

    task automatic doReset();
        clearReqs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clearReqs();
        bus.req_forward = 1'b1;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_IDLE) begin
                $display("FAIL reset cyc%0d: got %b want %b", k, obs(), O_IDLE);
                errCount++;
            end
        end
        reset_n = 1'b1;
        clearReqs();
    endtask

    task automatic test_forward();
        doReset();
        vecCount++;
        if (obs() !== O_IDLE) begin
            $display("FAIL forward_idle: got %b want %b", obs(), O_IDLE);
            errCount++;
        end
        bus.req_forward = 1'b1;
        tick();
        vecCount++;
        if (obs() !== O_FWD) begin
            $display("FAIL forward_start: got %b want %b", obs(), O_FWD);
            errCount++;
        end
    endtask

    task automatic test_hold_deadtime();
        doReset();
        bus.req_forward = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_FWD) begin
                $display("FAIL hold drive%0d: got %b want %b", k, obs(), O_FWD);
                errCount++;
            end
            if (k == 2) begin
                bus.req_turn = 1'b1;
                bus.turn_dir = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_DT) begin
                $display("FAIL hold dead%0d: got %b want %b", k, obs(), O_DT);
                errCount++;
            end
        end
        tick();
        vecCount++;
        if (obs() !== O_TR) begin
            $display("FAIL hold turn: got %b want %b", obs(), O_TR);
            errCount++;
        end
    endtask

    task automatic test_brake_preempt();
        doReset();
        bus.req_forward = 1'b1;
        tick();
        tick();
        bus.req_brake = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_BRK) begin
                $display("FAIL brake brk%0d: got %b want %b", k, obs(), O_BRK);
                errCount++;
            end
            if (k == 4) bus.req_brake = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_DT) begin
                $display("FAIL brake dead%0d: got %b want %b", k, obs(), O_DT);
                errCount++;
            end
        end
        tick();
        vecCount++;
        if (obs() !== O_FWD) begin
            $display("FAIL brake resume: got %b want %b", obs(), O_FWD);
            errCount++;
        end
    endtask

    task automatic test_release_idle();
        doReset();
        bus.req_forward = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        clearReqs();
        for (int k = 0; k < 4; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_DT) begin
                $display("FAIL release dead%0d: got %b want %b", k, obs(), O_DT);
                errCount++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_IDLE) begin
                $display("FAIL release idle%0d: got %b want %b", k, obs(), O_IDLE);
                errCount++;
            end
        end
    endtask

    task automatic test_direction_flip();
        doReset();
        bus.req_turn = 1'b1;
        bus.turn_dir = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_TL) begin
                $display("FAIL flip left%0d: got %b want %b", k, obs(), O_TL);
                errCount++;
            end
        end
        bus.turn_dir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_DT) begin
                $display("FAIL flip dead%0d: got %b want %b", k, obs(), O_DT);
                errCount++;
            end
        end
        tick();
        vecCount++;
        if (obs() !== O_TR) begin
            $display("FAIL flip right: got %b want %b", obs(), O_TR);
            errCount++;
        end
    endtask

    task automatic test_priority_deadtime_brake();
        doReset();
        bus.req_reverse = 1'b1;
        bus.req_turn    = 1'b1;
        bus.req_forward = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_REV) begin
                $display("FAIL prio rev%0d: got %b want %b", k, obs(), O_REV);
                errCount++;
            end
        end
        bus.req_reverse = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_DT) begin
                $display("FAIL prio dead%0d: got %b want %b", k, obs(), O_DT);
                errCount++;
            end
        end
        bus.req_brake = 1'b1;
        tick();
        vecCount++;
        if (obs() !== O_BRK) begin
            $display("FAIL prio dt_brake: got %b want %b", obs(), O_BRK);
            errCount++;
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        bus.req_brake = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vecCount++;
            if (obs() !== O_BRK) begin
                $display("FAIL midrst brk%0d: got %b want %b", k, obs(), O_BRK);
                errCount++;
            end
        end
        reset_n = 1'b0;
        bus.req_brake = 1'b0;
        bus.req_forward = 1'b1;
        tick();
        vecCount++;
        if (obs() !== O_IDLE) begin
            $display("FAIL midrst cleared: got %b want %b", obs(), O_IDLE);
            errCount++;
        end
        reset_n = 1'b1;
        tick();
        vecCount++;
        if (obs() !== O_FWD) begin
            $display("FAIL midrst forward: got %b want %b", obs(), O_FWD);
            errCount++;
        end
    endtask

`ifdef SOFT_START_EN
    task automatic test_soft_start();
        int onCnt;
        doReset();
        bus.req_forward = 1'b1;
        for (int s = 0; s < 4; s++) begin
            onCnt = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (bus.enables === 2'b11) onCnt++;
            end
            vecCount++;
            if (onCnt != 2 * (s + 1)) begin
                $display("FAIL soft step%0d: got %0d on-cycles want %0d", s, onCnt, 2 * (s + 1));
                errCount++;
            end
        end
    endtask
`endif

    initial begin
        clearReqs();
        test_reset();
        test_forward();
        test_hold_deadtime();
        test_brake_preempt();
        test_release_idle();
        test_direction_flip();
        test_priority_deadtime_brake();
        test_mid_reset();
`ifdef SOFT_START_EN
        test_soft_start();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
- Arbitrates the rover's motion requesters (obstacle brake, reverse, turn, line-follow forward) onto the single H-bridge input/enable pair.
- Enforces a minimum hold time per manoeuvre, a coast dead-time between direction changes, and a timed hard brake.
- Sits between the per-behaviour motion modules and the H-bridge routing logic.
- Replaces ad-hoc "previous motion" feedback with one registered owner of the H-bridge outputs.

Parameters:
- CNT_W, 16, width of the internal cycle counters.
- DEADTIME_CYC, 4, cycles of coast (0000, enables 00) inserted between differing drive patterns.
- MIN_HOLD_CYC, 8, minimum cycles a granted drive pattern is held before another pattern may win (brake excepted).
- BRAKE_CYC, 16, minimum cycles of hard stop once brake is entered.
- RAMP_CYC, 8, cycles per soft-start duty step (only used with SOFT_START_EN).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, synchronous active-low reset.
- req_brake, input, 1, obstacle/hard-stop request; highest priority.
- req_reverse, input, 1, reverse request; priority 2.
- req_turn, input, 1, turn request; priority 3.
- turn_dir, input, 1, turn direction: 1 = right, 0 = left; valid with req_turn.
- req_forward, input, 1, forward request; lowest priority.
- h_bridge_ins, output, 4, H-bridge input pattern.
- enables, output, 2, H-bridge enable pair.
- grant, output, 4, one-hot owner: bit3 brake, bit2 reverse, bit1 turn, bit0 forward; 0000 when no owner.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Fixed encodings:
  - INERTIAL_STOP = 0000
  - HARD_STOP = 1111
  - REVERSE = 0110
  - FORWARD = 1001
  - TURN_RIGHT = 0101
  - TURN_LEFT = 1010
- Winner is the highest-priority asserted request. Target pattern is derived from the winner; a turn with a different turn_dir counts as a different pattern.
- All outputs are registered. A request sampled at edge N is reflected on the outputs after edge N (1-cycle latency).
- Reset (reset_n low at an edge):
  - state = IDLE, h_bridge_ins = 0000, enables = 00, grant = 0000, busy = 0, all counters 0.
  - Reset overrides any state, including mid-BRAKE or mid-DEADTIME.
- States:
  - IDLE: outputs 0000 / 00 / grant 0000.
    - req_brake → BRAKE.
    - Else any other winner → DRIVE with that pattern; no dead-time is needed from standstill.
    - Else stay in IDLE.
  - DRIVE: outputs the latched pattern, enables 11, grant one-hot. hold_cnt increments each cycle, saturating.
    - req_brake → BRAKE immediately, pre-empting the hold time.
    - Else if hold_cnt < MIN_HOLD_CYC-1 → stay, ignoring request changes.
    - Else if no request → DEADTIME (exits to IDLE).
    - Else if target pattern differs from the latched pattern → DEADTIME.
    - Else stay.
  - DEADTIME: outputs 0000 / 00 / grant 0000; dt_cnt counts DEADTIME_CYC cycles.
    - req_brake at any cycle → BRAKE immediately.
    - At expiry the winner is re-evaluated: none → IDLE; otherwise → DRIVE with the new pattern, and hold_cnt is cleared.
  - BRAKE: outputs 1111 / 11 / grant 1000; br_cnt increments, saturating.
    - Leaves only when br_cnt ≥ BRAKE_CYC-1 and req_brake is low; it then goes to DEADTIME, never straight to DRIVE.
    - If req_brake stays high, BRAKE holds indefinitely.
- Counters are cleared on entry to their state. No counter wraps; each saturates at all-ones.
- Simultaneous requests: priority decides. Request changes during DEADTIME only matter at expiry (brake excepted).
- Parameter edge cases:
  - DEADTIME_CYC = 0 is not supported; the minimum is 1.
  - MIN_HOLD_CYC ≤ 1 means no hold.

Optional Feature:
- Macro: SOFT_START_EN.
- Defined:
  - In DRIVE only, enables are gated by a PWM. A free-running 2-bit phase counter is cleared by reset.
  - Duty level starts at 1 on DRIVE entry, increments every RAMP_CYC cycles, and saturates at 4.
  - enables = 11 when phase < duty, else 00.
  - BRAKE, DEADTIME and IDLE are unaffected.
- Undefined: enables = 11 for the whole of DRIVE; the ramp and phase logic are absent.

Test Plan:
- Forward from IDLE: req_forward=1 from cycle 0 → after edge 0: h_bridge_ins=1001, enables=11, grant=0001, busy=1.
- Hold then deadtime: forward driving, req_turn=1 with turn_dir=1 asserted on DRIVE cycle 2 → 1001 held through DRIVE cycle 7, then 4 cycles of 0000/00/grant 0000, then 0101/11/grant 0010.
- Brake preemption: req_brake pulsed high for 5 cycles during the DRIVE hold → next edge 1111/11/grant 1000; brake lasts exactly 16 cycles, then 4 cycles 0000, then 1001 if req_forward is still 1.
- Release to idle: all requests dropped after the hold expires → 4 cycles 0000, then IDLE with busy=0; grant stays 0000 throughout.
- Direction flip: turning left (1010); after the hold, turn_dir goes 0→1 → 4 cycles 0000, then 0101.
- Mid-operation reset: reset_n=0 for one edge during BRAKE cycle 3 → next outputs 0000/00/0000, busy=0; with req_forward=1, 1001 one edge after reset_n returns high. Under SOFT_START_EN, repeat the forward case → enables duty 1/4 for 8 cycles, then 2/4, 3/4, then 11 steady.
